// File: rtl/sobel_tile_scheduler.sv
// Tile scheduler for one sobel_convolution engine: gathers a 9x9 pixel tile from a
// byte stream, runs the engine once with a done timeout, then streams the result tile out.
module sobel_tile_scheduler #(
    parameter int PIX_W       = 8,
    parameter int N           = 9,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PIX_W-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIX_W-1:0]       out_data,
    output logic                   out_last,
    output logic                   eng_start,
    output logic [N*N*PIX_W-1:0]   eng_input_matrix,
    input  logic [N*N*PIX_W-1:0]   eng_output_matrix,
    input  logic                   eng_done,
    output logic                   busy,
    output logic                   timeout_err
);

    localparam int NPIX   = N * N;
    localparam int MW     = NPIX * PIX_W;
    localparam int CNT_W  = $clog2(NPIX);
    localparam int WAIT_W = $clog2(TIMEOUT_CYC);

    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NPIX - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_UNLOAD = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [MW-1:0]     pack_q, pack_d;
    logic [MW-1:0]     result_q, result_d;
    logic              timeout_err_q, timeout_err_d;

    // NOTE: every next-state value gets a default before the case so no path leaves a latch.
    always_comb begin
        state_d       = state_q;
        pix_cnt_d     = pix_cnt_q;
        res_cnt_d     = res_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        pack_d        = pack_q;
        result_d      = result_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    pack_d[int'(pix_cnt_q) * PIX_W +: PIX_W] = in_data;
                    if (pix_cnt_q == LAST_IDX) begin
                        pix_cnt_d = '0;
                        state_d   = S_START;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                // A done arriving on the timeout cycle still counts as a normal completion.
                if (eng_done) begin
                    result_d   = eng_output_matrix;
                    wait_cnt_d = '0;
                    state_d    = S_UNLOAD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    result_d      = '0;
                    timeout_err_d = 1'b1;
                    wait_cnt_d    = '0;
                    state_d       = S_UNLOAD;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_UNLOAD: begin
                if (out_ready) begin
                    if (res_cnt_q == LAST_IDX) begin
                        res_cnt_d = '0;
                        state_d   = S_LOAD;
                    end else begin
                        res_cnt_d = res_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    // NOTE: the pack register is reset because it drives eng_input_matrix directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_LOAD;
            pix_cnt_q     <= '0;
            res_cnt_q     <= '0;
            wait_cnt_q    <= '0;
            pack_q        <= '0;
            result_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_cnt_q     <= pix_cnt_d;
            res_cnt_q     <= res_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            pack_q        <= pack_d;
            result_q      <= result_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign in_ready         = (state_q == S_LOAD);
    assign out_valid        = (state_q == S_UNLOAD);
    assign out_data         = out_valid ? result_q[int'(res_cnt_q) * PIX_W +: PIX_W] : '0;
    assign out_last         = out_valid && (res_cnt_q == LAST_IDX);
    assign eng_start        = (state_q == S_START);
    assign eng_input_matrix = pack_q;
    assign busy             = !((state_q == S_LOAD) && (pix_cnt_q == '0));
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_sobel_tile_scheduler.sv
// Self-checking bench for sobel_tile_scheduler: a table of tile scenarios run against
// a behavioural engine model, plus a hand-written mid-load reset sequence.
module tb_sobel_tile_scheduler;

    localparam int PIX_W = 8;
    localparam int N     = 9;
    localparam int NPIX  = N * N;
    localparam int MW    = NPIX * PIX_W;
    localparam int TOUT  = 24;

    localparam int M_LAT   = 0;  // done after a fixed latency
    localparam int M_NEVER = 1;  // done never asserted
    localparam int M_HOLD  = 2;  // done held high, result updated on start

    typedef struct {
        bit ramp;     // pixels k = k instead of random
        int mode;
        int lat;
        bit gaps;     // random in_valid gaps
        bit stalls;   // out_ready=0 bursts
        int exp_gap;  // cycles from eng_start to first out_valid
        bit exp_err;  // timeout_err seen during unload
    } tile_vec_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [PIX_W-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PIX_W-1:0] out_data;
    logic             out_last;
    logic             eng_start;
    logic [MW-1:0]    eng_input_matrix;
    logic [MW-1:0]    eng_output_matrix = '0;
    logic             eng_done = 1'b0;
    logic             busy;
    logic             timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    sobel_tile_scheduler #(.PIX_W(PIX_W), .N(N), .TIMEOUT_CYC(TOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_data           (in_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_last          (out_last),
        .eng_start         (eng_start),
        .eng_input_matrix  (eng_input_matrix),
        .eng_output_matrix (eng_output_matrix),
        .eng_done          (eng_done),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: each result byte is 255 minus the input byte.
    int            eng_mode = M_LAT;
    int            eng_lat  = 1;
    int            eng_cnt  = 0;
    logic [MW-1:0] eng_cap  = '0;

    function automatic logic [MW-1:0] eng_fn(input logic [MW-1:0] m);
        logic [MW-1:0] r;
        for (int k = 0; k < NPIX; k++) r[k*PIX_W +: PIX_W] = 8'(255 - int'(m[k*PIX_W +: PIX_W]));
        return r;
    endfunction

    always @(posedge clk) begin
        if (eng_start) begin
            eng_cap <= eng_input_matrix;
            eng_cnt <= 0;
            if (eng_mode == M_HOLD) begin
                eng_done          <= 1'b1;
                eng_output_matrix <= eng_fn(eng_input_matrix);
            end else begin
                eng_done <= 1'b0;
                if (eng_mode == M_LAT) eng_cnt <= eng_lat;
            end
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done          <= 1'b1;
                eng_output_matrix <= eng_fn(eng_cap);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one full tile starting at a negedge while the scheduler is in LOAD.
    task automatic run_tile(input tile_vec_t v);
        logic [7:0]    pix[NPIX];
        logic [7:0]    exp_b[NPIX];
        logic [MW-1:0] pm;
        int            k, j, guard, c0, burst;
        bit            acc;

        for (int i = 0; i < NPIX; i++) begin
            pix[i] = v.ramp ? 8'(i) : 8'($urandom_range(0, 255));
            pm[i*PIX_W +: PIX_W] = pix[i];
            exp_b[i] = (v.mode == M_NEVER) ? 8'd0 : 8'(255 - int'(pix[i]));
        end
        eng_mode = v.mode;
        eng_lat  = v.lat;

        k = 0;
        guard = 0;
        while (k < NPIX) begin
            in_valid = v.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? pix[k] : 8'($urandom_range(0, 255));
            check("in_ready_load", 32'(in_ready), 32'd1);
            if (k > 0) check("busy_load", 32'(busy), 32'd1);
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            else if (++guard > 60) begin
                check("load_stuck", 32'(k), 32'(NPIX));
                return;
            end
        end

        // Offer junk while not loading; it must not be accepted.
        in_valid = 1'b1;
        in_data  = 8'($urandom_range(0, 255));
        check("eng_start_pulse", 32'(eng_start), 32'd1);
        check("in_ready_start", 32'(in_ready), 32'd0);
        check("busy_start", 32'(busy), 32'd1);
        check("input_matrix", 32'(eng_input_matrix == pm), 32'd1);
        c0 = cyc;
        tick();
        guard = 0;
        while (!out_valid) begin
            check("eng_start_once", 32'(eng_start), 32'd0);
            check("in_ready_wait", 32'(in_ready), 32'd0);
            if (++guard > 200) begin
                check("wait_stuck", 32'(out_valid), 32'd1);
                return;
            end
            tick();
        end
        check("unload_latency", 32'(cyc - c0), 32'(v.exp_gap));
        check("timeout_err", 32'(timeout_err), 32'(v.exp_err));

        j = 0;
        guard = 0;
        burst = 0;
        while (j < NPIX) begin
            if (v.stalls && burst == 0 && $urandom_range(0, 5) == 0) burst = $urandom_range(1, 5);
            out_ready = (burst == 0);
            if (burst > 0) burst--;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", 32'(out_data), 32'(exp_b[j]));
            check("out_last", 32'(out_last), 32'(j == NPIX - 1));
            check("in_ready_unload", 32'(in_ready), 32'd0);
            acc = out_ready && out_valid;
            tick();
            if (acc) j++;
            else if (++guard > 300) begin
                check("unload_stuck", 32'(j), 32'(NPIX));
                return;
            end
        end
        // Back in LOAD on the very next cycle.
        check("in_ready_after", 32'(in_ready), 32'd1);
        check("out_valid_after", 32'(out_valid), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    tile_vec_t vec[8];

    initial begin
        //           ramp mode     lat gaps stalls gap err
        vec[0] = '{1'b1, M_LAT,   20, 1'b0, 1'b0, 22, 1'b0};
        vec[1] = '{1'b0, M_LAT,    5, 1'b1, 1'b1,  7, 1'b0};
        vec[2] = '{1'b0, M_HOLD,   0, 1'b0, 1'b0,  2, 1'b0};
        vec[3] = '{1'b0, M_LAT,   23, 1'b0, 1'b0, 25, 1'b0};
        vec[4] = '{1'b0, M_LAT,    3, 1'b0, 1'b0,  5, 1'b0};
        vec[5] = '{1'b0, M_NEVER,  0, 1'b0, 1'b0, 25, 1'b1};
        vec[6] = '{1'b0, M_LAT,    7, 1'b1, 1'b1,  9, 1'b1};
        vec[7] = '{1'b1, M_LAT,    4, 1'b0, 1'b1,  6, 1'b0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_eng_start", 32'(eng_start), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_input_matrix", 32'(eng_input_matrix == '0), 32'd1);

        for (int i = 0; i < 7; i++) run_tile(vec[i]);

        // Abandon a tile after 40 pixels; the reset must discard them and clear the error.
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_data = 8'(k + 100);
            tick();
        end
        check("partial_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        check("mid_rst_input_matrix", 32'(eng_input_matrix == '0), 32'd1);
        check("mid_rst_eng_start", 32'(eng_start), 32'd0);

        run_tile(vec[7]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
